icache_fetch_ctrl: RTL and testbench

Request sequencer between the fetch stage and the i-cache.
- Accepts fetch addresses and issues them to the i-cache, with at most MAX_OUT requests outstanding.
- Pairs in-order i-cache responses with their addresses and buffers one response toward the fetch stage.
- On flush, silently drains the responses of every request issued before the flush, so stale instructions never reach decode.

---
 rtl/icache_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_icache_fetch_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_ctrl.sv
// Fetch-to-icache request sequencer: one pending address, bounded outstanding
// requests, in-order response pairing and flush-time draining of stale responses.
module icache_fetch_ctrl #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [XLEN-1:0]              req_addr_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  output logic [XLEN-1:0]              ic_addr_o,
  output logic                         ic_addr_valid_o,
  input  logic                         ic_addr_ready_i,
  input  logic [DATA_W-1:0]            ic_data_i,
  input  logic                         ic_data_valid_i,
  output logic                         ic_data_ready_o,
  output logic [DATA_W-1:0]            rsp_data_o,
  output logic [XLEN-1:0]              rsp_addr_o,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic                         idle_o
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW = $clog2(MAX_OUT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     drop_cnt, drop_next;
  logic [CW-1:0]     outstanding;
  logic              pend_valid;
  logic [XLEN-1:0]   pend_addr;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic [XLEN-1:0]   fifo_mem [MAX_OUT];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  logic req_hs, addr_hs, data_hs, rsp_load;

  assign req_ready_o     = !pend_valid && !flush_i;
  assign ic_addr_o       = pend_addr;
  assign ic_addr_valid_o = pend_valid && (outstanding < MAX_CNT) && !flush_i;
  assign ic_data_ready_o = (state == DRAIN) ? 1'b1 : (!rsp_valid || rsp_ready_i);

  assign req_hs  = req_valid_i && req_ready_o;
  assign addr_hs = ic_addr_valid_o && ic_addr_ready_i;
  assign data_hs = ic_data_valid_i && ic_data_ready_o;
  // Responses are delivered only in RUN and never in a flush cycle.
  assign rsp_load = data_hs && (state == RUN) && !flush_i;

  assign rsp_valid_o   = rsp_valid;
  assign rsp_addr_o    = rsp_addr;
  assign rsp_data_o    = rsp_data;
  assign outstanding_o = outstanding;
  assign idle_o        = !pend_valid && (outstanding == '0) && !rsp_valid;

  always_comb begin
    state_next = state;
    drop_next  = drop_cnt;
    if (flush_i) begin
      // Everything already issued is stale, minus a response consumed this cycle.
      drop_next  = outstanding - CW'(data_hs);
      state_next = (drop_next != '0) ? DRAIN : RUN;
    end else if (state == DRAIN && data_hs) begin
      drop_next = drop_cnt - 1'b1;
      if (drop_cnt == CW'(1)) state_next = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else if (flush_i) begin
      pend_valid <= 1'b0;
    end else if (req_hs) begin
      pend_valid <= 1'b1;
      pend_addr  <= req_addr_i;
    end else if (addr_hs) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({addr_hs, data_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (addr_hs) fifo_mem[wr_ptr] <= pend_addr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (addr_hs) wr_ptr <= wr_ptr + 1'b1;
      if (data_hs) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else if (flush_i) begin
      rsp_valid <= 1'b0;
    end else if (rsp_load) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= fifo_mem[rd_ptr];
      rsp_data  <= ic_data_i;
    end else if (rsp_ready_i) begin
      rsp_valid <= 1'b0;
    end
  end

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    data_hs |-> (outstanding != '0));

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed vector bench for icache_fetch_ctrl: per-cycle input/expected-output
// table plus hand-driven reset/flush and round-trip sequences.
module tb_icache_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, ic_addr_ready, ic_data_valid, rsp_ready;
  logic [63:0] req_addr;
  logic [31:0] ic_data;
  logic        req_ready, ic_addr_valid, ic_data_ready, rsp_valid, idle;
  logic [63:0] ic_addr, rsp_addr;
  logic [31:0] rsp_data;
  logic [2:0]  outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_fetch_ctrl #(.XLEN(64), .DATA_W(32), .MAX_OUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .ic_addr_o(ic_addr), .ic_addr_valid_o(ic_addr_valid), .ic_addr_ready_i(ic_addr_ready),
    .ic_data_i(ic_data), .ic_data_valid_i(ic_data_valid), .ic_data_ready_o(ic_data_ready),
    .rsp_data_o(rsp_data), .rsp_addr_o(rsp_addr), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .outstanding_o(outstanding), .idle_o(idle)
  );

  typedef struct {
    logic        rst, fl, rv;
    logic [63:0] ra;
    logic        iar, idv;
    logic [31:0] id;
    logic        rr;
    logic        e_rq, e_iav;
    logic [63:0] e_ia;
    logic        e_idr, e_rv;
    logic [63:0] e_raddr;
    logic [31:0] e_rdata;
    logic [2:0]  e_out;
    logic        e_idle;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst_v, fl, rv, input logic [63:0] ra,
                   input logic iar, idv, input logic [31:0] id, input logic rr,
                   input logic e_rq, e_iav, input logic [63:0] e_ia,
                   input logic e_idr, e_rv, input logic [63:0] e_raddr,
                   input logic [31:0] e_rdata, input logic [2:0] e_out, input logic e_idle);
    vec_t t;
    t = '{rst_v, fl, rv, ra, iar, idv, id, rr,
          e_rq, e_iav, e_ia, e_idr, e_rv, e_raddr, e_rdata, e_out, e_idle};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_v, fl, rv, input logic [63:0] ra,
                       input logic iar, idv, input logic [31:0] id, input logic rr);
    rst = rst_v; flush = fl; req_valid = rv; req_addr = ra;
    ic_addr_ready = iar; ic_data_valid = idv; ic_data = id; rsp_ready = rr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // rst fl rv ra         iar idv id           rr | rq iav ia        idr rv raddr      rdata        out idle
    // basic round trip
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    v(0,0,1,64'h1000,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    v(0,0,0,64'h0,     1,0,32'h0,       1,  0,1,64'h1000,  1,0,64'h0,     32'h0,       3'd0,0);
    v(0,0,0,64'h0,     1,1,32'h13,      1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,1,64'h1000,  32'h13,      3'd0,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    // saturate at MAX_OUT
    v(0,0,1,64'h0,     1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    v(0,0,1,64'h4,     1,0,32'h0,       1,  0,1,64'h0,     1,0,64'h0,     32'h0,       3'd0,0);
    v(0,0,1,64'h4,     1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,1,64'h8,     1,0,32'h0,       1,  0,1,64'h4,     1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,1,64'h8,     1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd2,0);
    v(0,0,1,64'hC,     1,0,32'h0,       1,  0,1,64'h8,     1,0,64'h0,     32'h0,       3'd2,0);
    v(0,0,1,64'hC,     1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd3,0);
    v(0,0,1,64'h10,    1,0,32'h0,       1,  0,1,64'hC,     1,0,64'h0,     32'h0,       3'd3,0);
    v(0,0,1,64'h10,    1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd4,0);
    v(0,0,0,64'h0,     1,0,32'h0,       1,  0,0,64'h0,     1,0,64'h0,     32'h0,       3'd4,0);
    v(0,0,0,64'h0,     1,1,32'hA0,      1,  0,0,64'h0,     1,0,64'h0,     32'h0,       3'd4,0);
    v(0,0,0,64'h0,     1,0,32'h0,       1,  0,1,64'h10,    1,1,64'h0,     32'hA0,      3'd3,0);
    v(0,0,0,64'h0,     1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd4,0);
    // flush with three outstanding, new request during drain
    v(0,0,0,64'h0,     0,1,32'hA4,      1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd4,0);
    v(0,1,0,64'h0,     0,0,32'h0,       0,  0,0,64'h0,     0,1,64'h4,     32'hA4,      3'd3,0);
    v(0,0,1,64'h2000,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd3,0);
    v(0,0,0,64'h0,     1,1,32'hB8,      1,  0,1,64'h2000,  1,0,64'h0,     32'h0,       3'd3,0);
    v(0,0,0,64'h0,     1,1,32'hBC,      1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd3,0);
    v(0,0,0,64'h0,     1,1,32'hC0,      1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd2,0);
    v(0,0,0,64'h0,     1,1,32'h20000013,1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,1,64'h2000,  32'h20000013,3'd0,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    // flush coinciding with a data handshake, outstanding=2
    v(0,0,1,64'h3000,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    v(0,0,1,64'h3004,  1,0,32'h0,       1,  0,1,64'h3000,  1,0,64'h0,     32'h0,       3'd0,0);
    v(0,0,1,64'h3004,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,0,64'h0,     1,0,32'h0,       1,  0,1,64'h3004,  1,0,64'h0,     32'h0,       3'd1,0);
    v(0,1,0,64'h0,     1,1,32'hD0,      1,  0,0,64'h0,     1,0,64'h0,     32'h0,       3'd2,0);
    v(0,0,0,64'h0,     1,1,32'hD4,      1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    // backpressure then simultaneous unload/load
    v(0,0,1,64'h4000,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    v(0,0,1,64'h4004,  1,0,32'h0,       1,  0,1,64'h4000,  1,0,64'h0,     32'h0,       3'd0,0);
    v(0,0,1,64'h4004,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,0,64'h0,     1,0,32'h0,       1,  0,1,64'h4004,  1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,0,64'h0,     0,1,32'hE0,      0,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd2,0);
    v(0,0,0,64'h0,     0,1,32'hE4,      0,  1,0,64'h0,     0,1,64'h4000,  32'hE0,      3'd1,0);
    v(0,0,0,64'h0,     0,1,32'hE4,      0,  1,0,64'h0,     0,1,64'h4000,  32'hE0,      3'd1,0);
    v(0,0,0,64'h0,     0,1,32'hE4,      1,  1,0,64'h0,     1,1,64'h4000,  32'hE0,      3'd1,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,1,64'h4004,  32'hE4,      3'd0,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    // reset during drain with two outstanding and a pending address
    v(0,0,1,64'h5000,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    v(0,0,1,64'h5004,  1,0,32'h0,       1,  0,1,64'h5000,  1,0,64'h0,     32'h0,       3'd0,0);
    v(0,0,1,64'h5004,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,0,64'h0,     1,0,32'h0,       1,  0,1,64'h5004,  1,0,64'h0,     32'h0,       3'd1,0);
    v(0,1,0,64'h0,     1,0,32'h0,       1,  0,0,64'h0,     1,0,64'h0,     32'h0,       3'd2,0);
    v(0,0,1,64'h6000,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd2,0);
    v(1,0,1,64'h6004,  0,0,32'h0,       1,  0,1,64'h6000,  1,0,64'h0,     32'h0,       3'd2,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    v(0,0,1,64'h7000,  1,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);
    v(0,0,0,64'h0,     1,0,32'h0,       1,  0,1,64'h7000,  1,0,64'h0,     32'h0,       3'd0,0);
    v(0,0,0,64'h0,     1,1,32'h77,      1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd1,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,1,64'h7000,  32'h77,      3'd0,0);
    v(0,0,0,64'h0,     0,0,32'h0,       1,  1,0,64'h0,     1,0,64'h0,     32'h0,       3'd0,1);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].fl, vecs[i].rv, vecs[i].ra,
            vecs[i].iar, vecs[i].idv, vecs[i].id, vecs[i].rr);
      #1;
      chk($sformatf("row%0d req_ready", i),     req_ready,     vecs[i].e_rq);
      chk($sformatf("row%0d ic_addr_valid", i), ic_addr_valid, vecs[i].e_iav);
      if (vecs[i].e_iav) chk($sformatf("row%0d ic_addr", i), ic_addr, vecs[i].e_ia);
      chk($sformatf("row%0d ic_data_ready", i), ic_data_ready, vecs[i].e_idr);
      chk($sformatf("row%0d rsp_valid", i),     rsp_valid,     vecs[i].e_rv);
      if (vecs[i].e_rv) begin
        chk($sformatf("row%0d rsp_addr", i), rsp_addr, vecs[i].e_raddr);
        chk($sformatf("row%0d rsp_data", i), rsp_data, vecs[i].e_rdata);
      end
      chk($sformatf("row%0d outstanding", i), outstanding, vecs[i].e_out);
      chk($sformatf("row%0d idle", i),        idle,        vecs[i].e_idle);
    end

    // reset and flush together: reset wins, nothing left to drain
    @(negedge clk); drive(0, 0, 1, 64'h8000, 1, 0, 32'h0, 1);
    @(negedge clk); drive(0, 0, 0, 64'h0,    1, 0, 32'h0, 1);
    @(negedge clk); drive(1, 1, 0, 64'h0,    0, 1, 32'h88, 1);
    @(negedge clk); drive(0, 0, 0, 64'h0,    0, 0, 32'h0, 1);
    #1;
    chk("rstflush outstanding", outstanding, 3'd0);
    chk("rstflush idle",        idle,        1'b1);
    chk("rstflush req_ready",   req_ready,   1'b1);
    chk("rstflush rsp_valid",   rsp_valid,   1'b0);

    // round trip after that reset must be delivered, not drained
    @(negedge clk); drive(0, 0, 1, 64'h9000, 1, 0, 32'h0, 1);
    @(negedge clk); drive(0, 0, 0, 64'h0,    1, 0, 32'h0, 1);
    #1;
    k = 0;
    while (!ic_addr_valid && k < 10) begin @(negedge clk); #1; k++; end
    chk("post-reset issue valid", ic_addr_valid, 1'b1);
    chk("post-reset issue addr",  ic_addr,       64'h9000);
    @(negedge clk); drive(0, 0, 0, 64'h0, 0, 1, 32'h99, 1);
    @(negedge clk); drive(0, 0, 0, 64'h0, 0, 0, 32'h0,  1);
    #1;
    k = 0;
    while (!rsp_valid && k < 10) begin @(negedge clk); #1; k++; end
    chk("post-reset rsp_valid", rsp_valid, 1'b1);
    chk("post-reset rsp_addr",  rsp_addr,  64'h9000);
    chk("post-reset rsp_data",  rsp_data,  32'h99);

    @(negedge clk);
    #1;
    chk("final idle", idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
